tmr_fanout_reg: RTL and testbench

- Registered, parametrised successor to the combinational triple fanout.
- Drives three independent register pipelines (copies A/B/C) from one input.
- Bitwise-votes the final stage and flags any copy disagreement.
- Keeps a saturating, clearable error counter.
- Sits at clock-domain-local TMR boundaries: triplicates a non-TMR source into a TMR region.

---
 rtl/tmr_fanout_reg.sv | 167 ++++++++++++++++
 tb/tb_tmr_fanout_reg.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_fanout_reg.sv
// -----------------------------------------------------------------------------
// tmr_fanout_reg
//
// Purpose:
//   Triplicates a non-TMR source into a TMR region. One input word is loaded
//   into three fully independent register pipelines (copies A/B/C). The final
//   stage of each copy is driven out, bitwise majority-voted, and compared. A
//   disagreement raises a sticky flag and bumps a saturating, clearable counter.
//
// Parameters:
//   WIDTH      data width per copy (>= 1)
//   STAGES     register stages per copy (1..4); latency in cycles
//   RESET_VAL  reset value of every data register
//   ERR_CNT_W  width of the mismatch-cycle counter (>= 1)
//
// Ports:
//   clk         rising-edge clock for all state
//   rst_n       synchronous active-low reset
//   in_valid    load enable for stage 0
//   in_data     source data
//   out_a/b/c   final-stage register of copy A/B/C
//   out_valid   in_valid delayed by STAGES cycles, aligned with the data
//   voted       bitwise majority of out_a/out_b/out_c (combinational)
//   mismatch    1 when the three outputs are not all equal (combinational)
//   err_sticky  set by any mismatch cycle, cleared by err_clr
//   err_cnt     saturating count of mismatch cycles, cleared by err_clr
//   err_clr     clears err_cnt and err_sticky (wins over a mismatch)
//
// Build option:
//   TMR_FANOUT_SCRUB_EN  when defined, disagreeing stage-0 copies are rewritten
//                        with their bitwise majority on idle (in_valid=0) cycles.
// -----------------------------------------------------------------------------
module tmr_fanout_reg #(
    parameter int               WIDTH     = 1,
    parameter int               STAGES    = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic [WIDTH-1:0]     out_a,
    output logic [WIDTH-1:0]     out_b,
    output logic [WIDTH-1:0]     out_c,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     voted,
    output logic                 mismatch,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 err_clr
);

    typedef logic [STAGES-1:0][WIDTH-1:0] pipe_t;

    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

    // The three copies are logically identical; the keep attribute stops
    // synthesis from merging them back into one register chain.
    (* keep = "true" *) pipe_t pipe_a_q;
    (* keep = "true" *) pipe_t pipe_b_q;
    (* keep = "true" *) pipe_t pipe_c_q;

    logic [WIDTH-1:0]     s0_a_d;
    logic [WIDTH-1:0]     s0_b_d;
    logic [WIDTH-1:0]     s0_c_d;
    logic [STAGES-1:0]    valid_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [ERR_CNT_W-1:0] err_cnt_d;
    logic                 err_sticky_q;
    logic                 err_sticky_d;

`ifdef TMR_FANOUT_SCRUB_EN
    logic [WIDTH-1:0] s0_maj;
    logic             s0_disagree;

    assign s0_maj      = (pipe_a_q[0] & pipe_b_q[0]) |
                         (pipe_a_q[0] & pipe_c_q[0]) |
                         (pipe_b_q[0] & pipe_c_q[0]);
    assign s0_disagree = (pipe_a_q[0] != pipe_b_q[0]) ||
                         (pipe_a_q[0] != pipe_c_q[0]);
`endif

    // Stage-0 next state. A fresh word always wins over scrubbing.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        s0_a_d = pipe_a_q[0];
        s0_b_d = pipe_b_q[0];
        s0_c_d = pipe_c_q[0];
`ifdef TMR_FANOUT_SCRUB_EN
        if (s0_disagree) begin
            s0_a_d = s0_maj;
            s0_b_d = s0_maj;
            s0_c_d = s0_maj;
        end
`endif
        if (in_valid) begin
            s0_a_d = in_data;
            s0_b_d = in_data;
            s0_c_d = in_data;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: every stage is reset, not just the last one, so a reset in the
        // middle of a burst discards all in-flight words.
        if (!rst_n) begin
            pipe_a_q <= {STAGES{RESET_VAL}};
            pipe_b_q <= {STAGES{RESET_VAL}};
            pipe_c_q <= {STAGES{RESET_VAL}};
            valid_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage read the value
            // its predecessor held before this edge, giving a true shift.
            pipe_a_q[0] <= s0_a_d;
            pipe_b_q[0] <= s0_b_d;
            pipe_c_q[0] <= s0_c_d;
            valid_q[0]  <= in_valid;
            for (int i = 1; i < STAGES; i++) begin
                pipe_a_q[i] <= pipe_a_q[i-1];
                pipe_b_q[i] <= pipe_b_q[i-1];
                pipe_c_q[i] <= pipe_c_q[i-1];
                valid_q[i]  <= valid_q[i-1];
            end
        end
    end

    assign out_a     = pipe_a_q[STAGES-1];
    assign out_b     = pipe_b_q[STAGES-1];
    assign out_c     = pipe_c_q[STAGES-1];
    assign out_valid = valid_q[STAGES-1];

    // Voting and comparison read the output ports so they see exactly what
    // downstream logic sees.
    assign voted    = (out_a & out_b) | (out_a & out_c) | (out_b & out_c);
    assign mismatch = (out_a != out_b) || (out_a != out_c);

    // Clear has priority; the counter stops at all-ones instead of wrapping.
    always_comb begin
        err_cnt_d    = err_cnt_q;
        err_sticky_d = err_sticky_q;
        if (err_clr) begin
            err_cnt_d    = '0;
            err_sticky_d = 1'b0;
        end else if (mismatch) begin
            err_sticky_d = 1'b1;
            if (err_cnt_q != CNT_MAX) begin
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            err_cnt_q    <= err_cnt_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign err_cnt    = err_cnt_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_tmr_fanout_reg.sv
// -----------------------------------------------------------------------------
// tb_tmr_fanout_reg
//
// Bench for tmr_fanout_reg. Three instances share the data inputs:
//   u_main  STAGES=3, RESET_VAL=8'hA5, ERR_CNT_W=8
//   u_sat   STAGES=1, RESET_VAL=8'h5A, ERR_CNT_W=2
//   u_thr   STAGES=2, RESET_VAL=8'h00, ERR_CNT_W=8
// Expected data is derived from a per-edge history of the inputs: the output
// after edge n is the last word accepted at or before edge n-STAGES+1, unless
// a reset edge intervenes.
// -----------------------------------------------------------------------------
module tb_tmr_fanout_reg;

    localparam int HMAX = 2048;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       m_clr, s_clr, t_clr;

    logic [7:0] m_a, m_b, m_c, m_voted, m_cnt;
    logic       m_v, m_mis, m_sticky;
    logic [7:0] s_a, s_b, s_c, s_voted;
    logic [1:0] s_cnt;
    logic       s_v, s_mis, s_sticky;
    logic [7:0] t_a, t_b, t_c, t_voted, t_cnt;
    logic       t_v, t_mis, t_sticky;

    int n_checks = 0;
    int n_err    = 0;

    logic       h_rst [HMAX];
    logic       h_val [HMAX];
    logic [7:0] h_dat [HMAX];
    int         n_edges = 0;

    logic [7:0] flip_val;
    logic [7:0] good_val;

    typedef struct {
        logic       vld;
        logic [7:0] dat;
        logic [7:0] exp_out;
        logic       exp_v;
    } tv_t;

    tv_t tv [18];

    always #5 clk = ~clk;

    tmr_fanout_reg #(.WIDTH(8), .STAGES(3), .RESET_VAL(8'hA5), .ERR_CNT_W(8)) u_main (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .out_a(m_a), .out_b(m_b), .out_c(m_c), .out_valid(m_v), .voted(m_voted),
        .mismatch(m_mis), .err_sticky(m_sticky), .err_cnt(m_cnt), .err_clr(m_clr)
    );

    tmr_fanout_reg #(.WIDTH(8), .STAGES(1), .RESET_VAL(8'h5A), .ERR_CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .out_a(s_a), .out_b(s_b), .out_c(s_c), .out_valid(s_v), .voted(s_voted),
        .mismatch(s_mis), .err_sticky(s_sticky), .err_cnt(s_cnt), .err_clr(s_clr)
    );

    tmr_fanout_reg #(.WIDTH(8), .STAGES(2), .RESET_VAL(8'h00), .ERR_CNT_W(8)) u_thr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .out_a(t_a), .out_b(t_b), .out_c(t_c), .out_valid(t_v), .voted(t_voted),
        .mismatch(t_mis), .err_sticky(t_sticky), .err_cnt(t_cnt), .err_clr(t_clr)
    );

    // Input history, one entry per rising edge.
    always @(posedge clk) begin
        if (n_edges < HMAX) begin
            h_rst[n_edges] <= ~rst_n;
            h_val[n_edges] <= in_valid;
            h_dat[n_edges] <= in_data;
        end
        n_edges <= n_edges + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Returns {out_valid, data} expected after the most recent edge.
    function automatic logic [8:0] model(input int s, input logic [7:0] rv);
        int         n;
        int         j;
        logic       v;
        logic [7:0] d;
        n = n_edges - 1;
        j = n - s + 1;
        v = (j >= 0) ? h_val[j] : 1'b0;
        d = rv;
        for (int k = n; k >= 0; k--) begin
            if (h_rst[k]) begin
                if (k >= j) v = 1'b0;
                d = rv;
                break;
            end
            if (k <= j && h_val[k]) begin
                d = h_dat[k];
                break;
            end
        end
        return {v, d};
    endfunction

    task automatic check_inst(input string tag, input logic [8:0] e,
                              input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                              input logic [7:0] vt, input logic v, input logic mis,
                              input logic [7:0] cnt, input logic sticky);
        check({tag, "_a"},      32'(a),      32'(e[7:0]));
        check({tag, "_b"},      32'(b),      32'(e[7:0]));
        check({tag, "_c"},      32'(c),      32'(e[7:0]));
        check({tag, "_voted"},  32'(vt),     32'(e[7:0]));
        check({tag, "_valid"},  32'(v),      32'(e[8]));
        check({tag, "_mis"},    32'(mis),    32'(0));
        check({tag, "_cnt"},    32'(cnt),    32'(0));
        check({tag, "_sticky"}, 32'(sticky), 32'(0));
    endtask

    task automatic check_model();
        check_inst("main", model(3, 8'hA5), m_a, m_b, m_c, m_voted, m_v, m_mis, m_cnt, m_sticky);
        check_inst("sat",  model(1, 8'h5A), s_a, s_b, s_c, s_voted, s_v, s_mis, 8'(s_cnt), s_sticky);
        check_inst("thr",  model(2, 8'h00), t_a, t_b, t_c, t_voted, t_v, t_mis, t_cnt, t_sticky);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        m_clr    = 1'b0;
        s_clr    = 1'b0;
        t_clr    = 1'b0;

        // Reset: two edges with rst_n low.
        repeat (2) @(negedge clk);
        check("rst_a",      32'(m_a),      32'h0A5);
        check("rst_b",      32'(m_b),      32'h0A5);
        check("rst_c",      32'(m_c),      32'h0A5);
        check("rst_valid",  32'(m_v),      32'(0));
        check("rst_cnt",    32'(m_cnt),    32'(0));
        check("rst_sticky", 32'(m_sticky), 32'(0));
        check("rst_mis",    32'(m_mis),    32'(0));
        check_model();
        rst_n = 1'b1;

        // Latency, STAGES=3: one-cycle pulse carrying 8'h3C.
        @(negedge clk);
        in_data  = 8'h3C;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
        check("lat_p0_valid", 32'(m_v), 32'(0));
        check("lat_p0_a",     32'(m_a), 32'h0A5);
        @(negedge clk);
        check("lat_p1_valid", 32'(m_v), 32'(0));
        @(negedge clk);
        check("lat_p2_valid", 32'(m_v), 32'(1));
        check("lat_p2_a",     32'(m_a), 32'h03C);
        check("lat_p2_b",     32'(m_b), 32'h03C);
        check("lat_p2_c",     32'(m_c), 32'h03C);
        check_model();
        @(negedge clk);
        check("lat_p3_valid", 32'(m_v), 32'(0));
        check("lat_p3_a",     32'(m_a), 32'h03C);

        // Throughput, STAGES=2: back-to-back words 0..15, then idle.
        for (int i = 0; i < 18; i++) begin
            tv[i].vld     = (i < 16);
            tv[i].dat     = (i < 16) ? 8'(i) : 8'hEE;
            tv[i].exp_out = (i == 0) ? 8'h00 : ((i <= 16) ? 8'(i - 1) : 8'd15);
            tv[i].exp_v   = (i >= 1) && (i <= 16);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 18; i++) begin
            in_valid = tv[i].vld;
            in_data  = tv[i].dat;
            @(negedge clk);
            check($sformatf("thr_out[%0d]", i),   32'(t_a),   32'(tv[i].exp_out));
            check($sformatf("thr_valid[%0d]", i), 32'(t_v),   32'(tv[i].exp_v));
            check($sformatf("thr_mis[%0d]", i),   32'(t_mis), 32'(0));
            check_model();
        end

        // Random traffic with occasional mid-stream resets.
        for (int i = 0; i < 300; i++) begin
            rst_n    = ($urandom_range(0, 39) != 0);
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            @(negedge clk);
            check_model();
        end

        // Fault on copy B of u_main: bit 0 flipped for five edges.
        rst_n    = 1'b1;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        good_val = model(3, 8'hA5) & 9'h0FF;
        flip_val = good_val ^ 8'h01;
        force u_main.out_b = flip_val;
        #1;
        check("flt_mis_on", 32'(m_mis),   32'(1));
        check("flt_voted",  32'(m_voted), 32'(good_val));
        repeat (5) @(negedge clk);
        check("flt_cnt",    32'(m_cnt),    32'(5));
        check("flt_sticky", 32'(m_sticky), 32'(1));
        release u_main.out_b;
        #1;
        check("flt_mis_off", 32'(m_mis), 32'(0));
        check("flt_b_back",  32'(m_b),   32'(good_val));
        @(negedge clk);
        check("flt_cnt_hold",    32'(m_cnt),    32'(5));
        check("flt_sticky_hold", 32'(m_sticky), 32'(1));
        m_clr = 1'b1;
        @(negedge clk);
        m_clr = 1'b0;
        check("clr_cnt",    32'(m_cnt),    32'(0));
        check("clr_sticky", 32'(m_sticky), 32'(0));

        // Saturation and clear-while-mismatching on the 2-bit counter.
        good_val = model(1, 8'h5A) & 9'h0FF;
        flip_val = good_val ^ 8'h01;
        force u_sat.out_b = flip_val;
        repeat (6) @(negedge clk);
        check("sat_cnt",    32'(s_cnt),    32'(3));
        check("sat_sticky", 32'(s_sticky), 32'(1));
        s_clr = 1'b1;
        @(negedge clk);
        s_clr = 1'b0;
        check("sat_clr_cnt",    32'(s_cnt),    32'(0));
        check("sat_clr_sticky", 32'(s_sticky), 32'(0));
        @(negedge clk);
        check("sat_resume_cnt",    32'(s_cnt),    32'(1));
        check("sat_resume_sticky", 32'(s_sticky), 32'(1));
        release u_sat.out_b;
        #1;
        check("sat_mis_off", 32'(s_mis), 32'(0));

`ifdef TMR_FANOUT_SCRUB_EN
        // Scrub on u_sat, whose only stage is stage 0.
        in_valid = 1'b1;
        in_data  = 8'h00;
        @(negedge clk);
        in_valid = 1'b0;
        force u_sat.pipe_c_q = 8'hFF;
        #1;
        release u_sat.pipe_c_q;
        #1;
        check("scr_mis_pre", 32'(s_mis), 32'(1));
        @(negedge clk);
        check("scr_a", 32'(s_a), 32'h000);
        check("scr_b", 32'(s_b), 32'h000);
        check("scr_c", 32'(s_c), 32'h000);
        force u_sat.pipe_c_q = 8'hFF;
        #1;
        release u_sat.pipe_c_q;
        in_valid = 1'b1;
        in_data  = 8'h11;
        @(negedge clk);
        in_valid = 1'b0;
        check("scr_ld_a", 32'(s_a), 32'h011);
        check("scr_ld_b", 32'(s_b), 32'h011);
        check("scr_ld_c", 32'(s_c), 32'h011);
`endif

        // Final reset clears counters and flags everywhere.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("end_sat_cnt",  32'(s_cnt),    32'(0));
        check("end_sat_stk",  32'(s_sticky), 32'(0));
        check("end_main_a",   32'(m_a),      32'h0A5);
        check_model();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
